// File: rtl/ov7670_capture_if.sv
// ============================================================================
// Module      : ov7670_capture_if
// Description : Bundle of camera-side inputs and frame-buffer-side outputs
//               for ov7670_capture.
//               master : drives camera/enable, observes frame-buffer outputs
//               slave  : the capture block
// Ports       : vsync, href, d[7:0], enable   (master -> slave)
//               pixel[15:0], we, addr[AW-1:0],
//               frame_done, line_err          (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ov7670_capture_if #(
   parameter int AW = 17
);
   logic          vsync;
   logic          href;
   logic [7:0]    d;
   logic          enable;
   logic [15:0]   pixel;
   logic          we;
   logic [AW-1:0] addr;
   logic          frame_done;
   logic          line_err;

   modport master (
      output vsync, href, d, enable,
      input  pixel, we, addr, frame_done, line_err
   );

   modport slave (
      input  vsync, href, d, enable,
      output pixel, we, addr, frame_done, line_err
   );
endinterface

`default_nettype wire

// File: rtl/ov7670_capture.sv
// ============================================================================
// Module      : ov7670_capture
// Description : OV7670 byte-stream capture into a frame buffer. Pairs of
//               camera bytes form RGB555 words written at y*H_ACTIVE+x.
//               Frames are armed only after a full vsync high->low sequence.
// Ports       : pixclk     - camera PCLK, all logic on its rising edge
//               reset      - asynchronous active-high reset
//               cam.vsync/href/d/enable - camera timing, data, capture enable
//               cam.pixel/we/addr       - frame-buffer write port
//               cam.frame_done          - pulse after last write of a frame
//               cam.line_err            - sticky odd-byte-count line flag
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ov7670_capture #(
   parameter int H_ACTIVE = 320,
   parameter int V_ACTIVE = 240,
   parameter int AW       = 17
) (
   input  logic             pixclk,
   input  logic             reset,
   ov7670_capture_if.slave  cam
);

   localparam int XW = $clog2(H_ACTIVE + 1);
   localparam int YW = $clog2(V_ACTIVE + 1);

   localparam logic [XW-1:0] c_X_MAX  = XW'(H_ACTIVE);
   localparam logic [YW-1:0] c_Y_MAX  = YW'(V_ACTIVE);
   localparam logic [YW-1:0] c_Y_LAST = YW'(V_ACTIVE - 1);
   localparam logic [AW-1:0] c_H_STEP = AW'(H_ACTIVE);

   typedef enum logic [1:0] {
      ST_SYNC   = 2'd0,
      ST_VBLANK = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_SKIP   = 2'd3
   } state_t;

   // Input stage S1 plus one more tap of vsync/href for edge detection
   logic          r_vs;
   logic          r_hr;
   logic [7:0]    r_d;
   logic          r_vs_q;
   logic          r_hr_q;

   state_t        r_state;
   state_t        w_state_nxt;

   logic          w_vs_rise;
   logic          w_vs_fall;
   logic          w_frame_start;
   logic          w_frame_end;
   logic          w_in_frame;
   logic          w_done;

   logic          r_phase;
   logic [6:0]    r_hi;       // bit 7 of the high byte is discarded by RGB555
   logic [XW-1:0] r_x;
   logic [YW-1:0] r_y;
   logic [AW-1:0] r_base;     // y*H_ACTIVE, kept incrementally
   logic          r_any;      // at least one byte seen in the current line
   logic          r_wrote;    // at least one write done in the current frame

   logic [15:0]   r_pixel;
   logic          r_we;
   logic [AW-1:0] r_addr;
   logic          r_frame_done;
   logic          r_line_err;

   assign w_vs_rise = r_vs & ~r_vs_q;
   assign w_vs_fall = ~r_vs & r_vs_q;

   // ---------------------------------------------------------------------
   // Input registration
   // ---------------------------------------------------------------------
   always_ff @(posedge pixclk or posedge reset) begin
      if (reset) begin
         r_vs   <= 1'b0;
         r_hr   <= 1'b0;
         r_d    <= 8'd0;
         r_vs_q <= 1'b0;
         r_hr_q <= 1'b0;
      end else begin
         r_vs   <= cam.vsync;
         r_hr   <= cam.href;
         r_d    <= cam.d;
         r_vs_q <= r_vs;
         r_hr_q <= r_hr;
      end
   end

   // ---------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------
   always_ff @(posedge pixclk or posedge reset) begin
      if (reset) begin
         r_state <= ST_SYNC;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // FSM next state and frame-level controls
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt   = r_state;
      w_frame_start = 1'b0;
      w_frame_end   = 1'b0;
      w_in_frame    = 1'b0;
      w_done        = 1'b0;
      case (r_state)
         ST_SYNC: begin
            // Any partial frame in flight at reset release is discarded here
            if (r_vs) begin
               w_state_nxt = ST_VBLANK;
            end
         end
         ST_VBLANK: begin
            if (w_vs_fall) begin
               w_frame_start = 1'b1;
               w_state_nxt   = cam.enable ? ST_ACTIVE : ST_SKIP;
            end
         end
         ST_ACTIVE, ST_SKIP: begin
            // vsync rising takes priority over any byte in the same cycle,
            // so a line still open at that point is abandoned
            if (w_vs_rise) begin
               w_frame_end = 1'b1;
               w_done      = (r_state == ST_ACTIVE) && r_wrote;
               w_state_nxt = ST_VBLANK;
            end else begin
               w_in_frame = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_SYNC;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Line/pixel datapath and outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge pixclk or posedge reset) begin
      if (reset) begin
         r_phase      <= 1'b0;
         r_hi         <= 7'd0;
         r_x          <= '0;
         r_y          <= '0;
         r_base       <= '0;
         r_any        <= 1'b0;
         r_wrote      <= 1'b0;
         r_pixel      <= 16'd0;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_frame_done <= 1'b0;
         r_line_err   <= 1'b0;
      end else begin
         r_we         <= 1'b0;
         r_frame_done <= w_done;

         if (w_frame_start) begin
            r_phase <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_base  <= '0;
            r_any   <= 1'b0;
            r_wrote <= 1'b0;
            r_addr  <= '0;
         end else if (w_frame_end) begin
            r_phase <= 1'b0;
            r_x     <= '0;
            r_any   <= 1'b0;
         end else if (w_in_frame) begin
            if (r_hr) begin
               r_any   <= 1'b1;
               r_phase <= ~r_phase;
               if (!r_phase) begin
                  r_hi <= r_d[6:0];
               end else begin
                  // x keeps counting in SKIP too; it saturates at H_ACTIVE
                  if (r_x < c_X_MAX) begin
                     r_x <= r_x + XW'(1);
                  end
                  if ((r_state == ST_ACTIVE) && (r_x < c_X_MAX) && (r_y < c_Y_MAX)) begin
                     r_we    <= 1'b1;
                     r_pixel <= {1'b0, r_hi, r_d};
                     r_addr  <= r_base + AW'(r_x);
                     r_wrote <= 1'b1;
                  end
               end
            end else if (r_hr_q) begin
               // href falling: close the line, drop any dangling high byte
               r_x     <= '0;
               r_phase <= 1'b0;
               r_any   <= 1'b0;
               if (r_phase) begin
                  r_line_err <= 1'b1;
               end
               if (r_any) begin
                  if (r_y < c_Y_MAX) begin
                     r_y <= r_y + YW'(1);
                  end
                  // base stops at the last line so it never leaves the buffer
                  if (r_y < c_Y_LAST) begin
                     r_base <= r_base + c_H_STEP;
                  end
               end
            end
         end
      end
   end

   assign cam.pixel      = r_pixel;
   assign cam.we         = r_we;
   assign cam.addr       = r_addr;
   assign cam.frame_done = r_frame_done;
   assign cam.line_err   = r_line_err;

endmodule

`default_nettype wire

// File: tb/tb_ov7670_capture.sv
// ============================================================================
// Module      : tb_ov7670_capture
// Description : Self-checking bench for ov7670_capture using a reduced frame
//               (16x8). Random camera bytes are scored against a
//               line/pair-level reference model of the expected writes.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ov7670_capture;

   localparam int H  = 16;
   localparam int V  = 8;
   localparam int AW = 7;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   ov7670_capture_if #(.AW(AW)) cam ();

   ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .AW(AW)) dut (
      .pixclk (clk),
      .reset  (rst),
      .cam    (cam)
   );

   typedef struct {
      int          cyc;
      int          addr;
      logic [15:0] pix;
   } wr_t;

   wr_t         exp_q[$];
   int          done_q[$];
   logic [7:0]  pre_q[$];

   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   int          drv_cyc;
   int          n_wr   = 0;
   int          w0;
   logic [15:0] obs_mem [0:H*V-1];
   wr_t         m_e;

   // reference-model state
   bit          m_active = 1'b0;
   bit          m_frame  = 1'b0;
   bit          m_wrote  = 1'b0;
   bit          exp_err  = 1'b0;
   int          m_y      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Output monitor / scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            check("missed_we", 32'd0, 32'd1);
            void'(exp_q.pop_front());
         end
         if (cam.we === 1'b1) begin
            n_wr++;
            if (exp_q.size() == 0) begin
               check("unexpected_we", 32'd1, 32'd0);
            end else begin
               m_e = exp_q.pop_front();
               check("we_cycle", cyc, m_e.cyc);
               check("addr", 32'(cam.addr), m_e.addr);
               check("pixel", 32'(cam.pixel), 32'(m_e.pix));
               if (int'(cam.addr) < H*V) obs_mem[cam.addr] = cam.pixel;
            end
         end
         if (cam.frame_done === 1'b1) begin
            if (done_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
            else check("done_cycle", cyc, done_q.pop_front());
         end
         while (done_q.size() > 0 && done_q[0] < cyc) begin
            check("missed_done", 32'd0, 32'd1);
            void'(done_q.pop_front());
         end
      end
   end

   task automatic step(input bit vs, input bit hr, input logic [7:0] b);
      @(negedge clk);
      cam.vsync = vs;
      cam.href  = hr;
      cam.d     = b;
      drv_cyc   = cyc;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_we"},    32'(cam.we),         32'd0);
      check({tag, "_done"},  32'(cam.frame_done), 32'd0);
      check({tag, "_err"},   32'(cam.line_err),   32'd0);
      check({tag, "_pixel"}, 32'(cam.pixel),      32'd0);
      check({tag, "_addr"},  32'(cam.addr),       32'd0);
   endtask

   task automatic start_frame(input bit en);
      cam.enable = en;
      repeat (3) step(1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00);
      m_active = en;
      m_frame  = 1'b1;
      m_y      = 0;
      m_wrote  = 1'b0;
      repeat (2) step(1'b0, 1'b0, 8'h00);
   endtask

   task automatic end_frame();
      step(1'b1, 1'b0, 8'h00);
      if (m_active && m_wrote) done_q.push_back(drv_cyc + 2);
      m_active = 1'b0;
      m_frame  = 1'b0;
      repeat (3) step(1'b1, 1'b0, 8'h00);
   endtask

   // One line of n bytes. rst_at >= 0 pulses reset after that byte.
   // abandon=1 raises vsync while href is still high after the last byte.
   task automatic send_line(input int n, input bit abandon, input int rst_at);
      logic [7:0] hi;
      logic [7:0] b;
      wr_t        e;
      hi = 8'h00;
      for (int i = 0; i < n; i++) begin
         if (pre_q.size() > 0) b = pre_q.pop_front();
         else b = 8'($urandom);
         step(1'b0, 1'b1, b);
         if (i == rst_at) begin
            rst = 1'b1;
            exp_q.delete();
            done_q.delete();
            m_active = 1'b0;
            m_frame  = 1'b0;
            exp_err  = 1'b0;
         end
         if (rst_at >= 0 && i == rst_at + 1) check_reset("midrst");
         if (rst_at >= 0 && i == rst_at + 3) rst = 1'b0;
         if (i % 2 == 0) begin
            hi = b;
         end else if (m_active && (i / 2) < H && m_y < V) begin
            e.cyc  = drv_cyc + 2;
            e.addr = m_y * H + i / 2;
            e.pix  = {1'b0, hi[6:0], b};
            exp_q.push_back(e);
            m_wrote = 1'b1;
         end
      end
      if (abandon) begin
         step(1'b1, 1'b1, 8'($urandom));
         if (m_active && m_wrote) done_q.push_back(drv_cyc + 2);
         m_active = 1'b0;
         m_frame  = 1'b0;
         repeat (3) step(1'b1, 1'b0, 8'h00);
      end else begin
         repeat ($urandom_range(1, 3)) step(1'b0, 1'b0, 8'h00);
         if (m_frame && n > 0 && m_y < V) m_y++;
         if (m_frame && (n % 2 == 1)) exp_err = 1'b1;
      end
   endtask

   initial begin
      cam.vsync  = 1'b0;
      cam.href   = 1'b0;
      cam.d      = 8'h00;
      cam.enable = 1'b0;
      rst        = 1'b1;
      repeat (3) @(negedge clk);
      check_reset("por");
      rst = 1'b0;

      // Frame A: full frame, first two pixels directed
      pre_q = '{8'h7C, 8'h1F, 8'h03, 8'hE0};
      start_frame(1'b1);
      w0 = n_wr;
      for (int l = 0; l < V; l++) send_line(2*H, 1'b0, -1);
      end_frame();
      check("A_writes", n_wr - w0, H*V);
      check("A_pix0", 32'(obs_mem[0]), 32'h7C1F);
      check("A_pix1", 32'(obs_mem[1]), 32'h03E0);
      check("A_line_err", 32'(cam.line_err), 32'd0);

      // Frame B: overlong line, odd line, empty line, random lengths, extra lines
      start_frame(1'b1);
      for (int l = 0; l < V + 2; l++) begin
         if (l == 1)      send_line(2*H + 2, 1'b0, -1);
         else if (l == 3) send_line(2*H + 1, 1'b0, -1);
         else if (l == 5) send_line(0, 1'b0, -1);
         else             send_line($urandom_range(1, 2*H + 6), 1'b0, -1);
      end
      end_frame();
      check("B_line_err", 32'(cam.line_err), 32'(exp_err));
      check("B_line_err_set", 32'(cam.line_err), 32'd1);

      // Frame C: disabled at vsync fall, enabled mid-frame
      start_frame(1'b0);
      w0 = n_wr;
      for (int l = 0; l < 2; l++) send_line(2*H, 1'b0, -1);
      cam.enable = 1'b1;
      for (int l = 2; l < V; l++) send_line(2*H, 1'b0, -1);
      end_frame();
      check("C_writes", n_wr - w0, 0);
      check("C_line_err_sticky", 32'(cam.line_err), 32'd1);

      // Frame D: enabled at vsync fall, disabled mid-frame
      start_frame(1'b1);
      w0 = n_wr;
      for (int l = 0; l < 3; l++) send_line(2*H, 1'b0, -1);
      cam.enable = 1'b0;
      for (int l = 3; l < V; l++) send_line(2*H, 1'b0, -1);
      end_frame();
      check("D_writes", n_wr - w0, H*V);

      // Frame E: vsync rises while a line is still open
      start_frame(1'b1);
      w0 = n_wr;
      for (int l = 0; l < 2; l++) send_line(2*H, 1'b0, -1);
      send_line(6, 1'b1, -1);
      check("E_writes", n_wr - w0, 2*H + 3);

      // Frame F: reset mid-line, remaining lines without vsync
      start_frame(1'b1);
      for (int l = 0; l < 2; l++) send_line(2*H, 1'b0, -1);
      send_line(2*H, 1'b0, 9);
      w0 = n_wr;
      for (int l = 3; l < V; l++) send_line(2*H, 1'b0, -1);
      repeat (3) step(1'b0, 1'b0, 8'h00);
      check("F_post_reset_writes", n_wr - w0, 0);
      check("F_line_err_cleared", 32'(cam.line_err), 32'd0);

      // Frame G: capture resumes after a fresh vsync sequence
      start_frame(1'b1);
      w0 = n_wr;
      for (int l = 0; l < V; l++) send_line(2*H, 1'b0, -1);
      end_frame();
      check("G_writes", n_wr - w0, H*V);

      repeat (5) step(1'b1, 1'b0, 8'h00);
      check("pending_writes", exp_q.size(), 0);
      check("pending_done", done_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
